// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode
// encodings, FSM state type and two's-complement helpers.
package mdu_pkg;

  // Helpers work on a wide fixed width. Callers extend their operands
  // and then cast the result back down, so any W up to MAX_W/2 can use them.
  localparam int MAX_W = 256;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  // Two's-complement negation.
  function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  // Magnitude of a sign-extended value. The most negative W-bit value maps
  // to 1<<(W-1), which still fits in W unsigned bits after truncation.
  function automatic logic [MAX_W-1:0] abs_w(input logic signed [MAX_W-1:0] x);
    return (x < 0) ? negate(x) : x;
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// (W+1)-bit adder/subtractor shared by the multiply and divide steps.
// In subtract mode cout is the "no borrow" flag, i.e. x >= y.
module mdu_addsub #(
  parameter int W = 32
) (
  input  logic [W:0] x,
  input  logic [W:0] y,
  input  logic       sub,
  output logic [W:0] sum,
  output logic       cout
);

  logic [W+1:0] full;

  // x + y, or x + ~y + 1 when subtracting.
  always_comb begin
    full = {1'b0, x} + {1'b0, y ^ {(W+1){sub}}} + {{(W+1){1'b0}}, sub};
    sum  = full[W:0];
    cout = full[W+1];
  end

endmodule

// File: rtl/iterative_mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU use a shift-add loop, DIV/DIVU a restoring shift-subtract loop;
// both operate on magnitudes and apply the sign in the FIX state.
// W must be even, at least 4 and at most 128.
module iterative_mdu
  import mdu_pkg::*;
#(
  parameter  int W  = 32,
  localparam int CW = $clog2(W+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  state_t        state;
  logic [CW-1:0] cnt;
  // acc: upper product half / partial remainder.
  // mq:  multiplier shifting into lower product / dividend shifting into quotient.
  logic [W-1:0]  acc;
  logic [W-1:0]  mq;
  logic [W-1:0]  mcand;
  logic          neg_q;
  logic          neg_r;
  logic          is_div;
  logic          dz;

  logic          signed_op;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;

  logic [W:0]    add_x;
  logic [W:0]    add_y;
  logic [W:0]    add_sum;
  logic          add_cout;

  logic [2*W-1:0] prod_raw;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;

  // Operand magnitudes for the request currently presented at the inputs.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_mag     = signed_op ? W'(abs_w({{(MAX_W-W){a[W-1]}}, a})) : a;
    b_mag     = signed_op ? W'(abs_w({{(MAX_W-W){b[W-1]}}, b})) : b;
  end

  // Adder operands: add multiplicand when the multiplier LSB is set, or
  // trial-subtract the divisor from the shifted partial remainder.
  always_comb begin
    if (is_div) begin
      add_x = {acc, mq[W-1]};
      add_y = {1'b0, mcand};
    end else begin
      add_x = {1'b0, acc};
      add_y = {1'b0, mcand & {W{mq[0]}}};
    end
  end

  mdu_addsub #(.W(W)) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sub  (is_div),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Sign correction of the finished magnitude results.
  always_comb begin
    prod_raw = {acc, mq};
    prod_fix = neg_q ? (2*W)'(negate({{(MAX_W-2*W){1'b0}}, prod_raw})) : prod_raw;
    q_fix    = neg_q ? W'(negate({{(MAX_W-W){1'b0}}, mq}))  : mq;
    r_fix    = neg_r ? W'(negate({{(MAX_W-W){1'b0}}, acc})) : acc;
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      mq          <= '0;
      mcand       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          // start has priority over abort here since abort only acts when busy.
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc    <= '0;
                mq     <= b_mag;
                mcand  <= a_mag;
                neg_q  <= signed_op & (a[W-1] ^ b[W-1]);
                neg_r  <= 1'b0;
                is_div <= 1'b0;
                dz     <= 1'b0;
                cnt    <= CW'(W);
                busy   <= 1'b1;
                state  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                acc    <= '0;
                mq     <= a_mag;
                mcand  <= b_mag;
                neg_q  <= signed_op & (a[W-1] ^ b[W-1]);
                neg_r  <= signed_op & a[W-1];
                is_div <= 1'b1;
                dz     <= (b == '0);
                cnt    <= CW'(W);
                busy   <= 1'b1;
                state  <= S_DIV;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (state == S_MUL) begin
              acc <= add_sum[W:1];
              mq  <= {add_sum[0], mq[W-1:1]};
            end else begin
              acc <= add_cout ? add_sum[W-1:0] : add_x[W-1:0];
              mq  <= {mq[W-2:0], add_cout};
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!abort) begin
            // A zero divisor leaves the dividend in the remainder, and the
            // remainder sign restores it to a exactly; only LO is forced.
            if (is_div) begin
              lo <= dz ? '1 : q_fix;
              hi <= r_fix;
            end else begin
              hi <= prod_fix[2*W-1:W];
              lo <= prod_fix[W-1:0];
            end
            done        <= 1'b1;
            div_by_zero <= dz;
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_mdu.sv
// Directed testbench for iterative_mdu at W=32.
module tb_iterative_mdu;

  localparam int W = 32;

  localparam logic [2:0] T_MULT  = 3'b000;
  localparam logic [2:0] T_MULTU = 3'b001;
  localparam logic [2:0] T_DIV   = 3'b010;
  localparam logic [2:0] T_DIVU  = 3'b011;
  localparam logic [2:0] T_MTHI  = 3'b100;
  localparam logic [2:0] T_MTLO  = 3'b101;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  iterative_mdu #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the falling edge after edge 0.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges after edge 0 until done is seen, bounded.
  task automatic wait_done(inout int cyc);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc;
    logic seen;

    vecs[0] = '{"mult_neg3x5",   T_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1] = '{"multu_max",     T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{"div_neg7by2",   T_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{"div_overflow",  T_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4] = '{"divu_by0",      T_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{"divu_100by7",   T_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[6] = '{"mult_minsq",    T_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7] = '{"div_7byneg2",   T_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8] = '{"div_neg16by0",  T_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_dz", 64'(div_by_zero), 64'h0);
    rst_n = 1'b1;

    // Table-driven arithmetic vectors
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_busy"}, 64'(busy), 64'h1);
      cyc = 0;
      wait_done(cyc);
      chk({vecs[i].name, "_latency"}, 64'(cyc), 64'd33);
      chk({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
      chk({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
      chk({vecs[i].name, "_dz"}, 64'(div_by_zero), 64'(vecs[i].dz));
      chk({vecs[i].name, "_busy_end"}, 64'(busy), 64'h0);
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, 64'(done), 64'h0);
      chk({vecs[i].name, "_dz_pulse"}, 64'(div_by_zero), 64'h0);
    end

    // Second start during a MULT is ignored and not queued
    issue(T_MULT, 32'd3, 32'd4);
    cyc = 0;
    repeat (5) begin @(negedge clk); cyc++; end
    op = T_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    wait_done(cyc);
    chk("ignored_start_latency", 64'(cyc), 64'd33);
    chk("ignored_start_hi", 64'(hi), 64'h0);
    chk("ignored_start_lo", 64'(lo), 64'hC);
    @(negedge clk);
    chk("ignored_start_not_queued", 64'(busy), 64'h0);

    // New start accepted in the done cycle
    issue(T_MULTU, 32'd6, 32'd7);
    cyc = 0;
    wait_done(cyc);
    chk("b2b_first_lo", 64'(lo), 64'h2A);
    op = T_DIVU; a = 32'h2A; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'h1);
    chk("b2b_done_low", 64'(done), 64'h0);
    cyc = 0;
    wait_done(cyc);
    chk("b2b_latency", 64'(cyc), 64'd33);
    chk("b2b_lo", 64'(lo), 64'h7);
    chk("b2b_hi", 64'(hi), 64'h0);

    // Abort at cycle 10 keeps HI/LO and produces no done
    issue(T_DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'h0);
    chk("abort_hi", 64'(hi), 64'h0);
    chk("abort_lo", 64'(lo), 64'h7);

    // Abort together with start in IDLE: start wins
    @(negedge clk);
    op = T_MULT; a = 32'd2; b = 32'hFFFFFFFD; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 64'(busy), 64'h1);
    cyc = 0;
    wait_done(cyc);
    chk("abort_start_latency", 64'(cyc), 64'd33);
    chk("abort_start_hi", 64'(hi), 64'hFFFFFFFF);
    chk("abort_start_lo", 64'(lo), 64'hFFFFFFFA);

    // MTHI / MTLO write one edge after start, no busy or done
    issue(T_MTHI, 32'hCAFEF00D, 32'h0);
    chk("mthi_hi", 64'(hi), 64'hCAFEF00D);
    chk("mthi_lo", 64'(lo), 64'hFFFFFFFA);
    chk("mthi_done", 64'(done), 64'h0);
    chk("mthi_busy", 64'(busy), 64'h0);
    issue(T_MTLO, 32'h12345678, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'h12345678);
    chk("mtlo_hi", 64'(hi), 64'hCAFEF00D);
    chk("mtlo_done", 64'(done), 64'h0);

    // Reserved opcode is ignored
    issue(3'b110, 32'hDEADBEEF, 32'h1);
    chk("rsvd_busy", 64'(busy), 64'h0);
    chk("rsvd_hi", 64'(hi), 64'hCAFEF00D);
    chk("rsvd_lo", 64'(lo), 64'h12345678);
    @(negedge clk);
    chk("rsvd_done", 64'(done), 64'h0);

    // Asynchronous reset in the middle of an operation
    issue(T_MULTU, 32'd5, 32'd5);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'h0);
    chk("midrst_lo", 64'(lo), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_done", 64'(done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unit works normally after the mid-operation reset
    issue(T_MULTU, 32'd5, 32'd5);
    cyc = 0;
    wait_done(cyc);
    chk("post_rst_latency", 64'(cyc), 64'd33);
    chk("post_rst_lo", 64'(lo), 64'h19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_mdu.md
# iterative_mdu

Parametrised multi-cycle multiply/divide unit owning the architectural HI/LO registers. It replaces the combinational hi/lo path of the single-cycle ALU. The processor issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start/busy/done handshake. Results land in internal HI/LO registers that the datapath reads at any time.

## Interface
Parameters:
- W, 32: operand and HI/LO width; must be even and ≥ 4.
- CW, $clog2(W+1): iteration-counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
- a  in  W  rs operand (dividend / multiplicand / MTxx source).
- b  in  W  rt operand (divisor / multiplier).
- abort  in  1  synchronous cancel of an in-flight operation.
- busy  out  1  high while an iterative op is in flight.
- done  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
- div_by_zero  out  1  pulses with done when a DIV/DIVU had b == 0.
- hi  out  W  HI register.
- lo  out  W  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op MULT/MULTU:
  - Latch operands. Signed op: store magnitudes and result sign = a[W-1]^b[W-1].
  - Counter = W, go to MUL.
- IDLE, start=1, op DIV/DIVU:
  - Same latching. Quotient sign = a^b sign bits; remainder sign = a sign.
  - Go to DIV.
- IDLE, start=1, op MTHI/MTLO:
  - Write a into HI or LO on that edge.
  - Stay IDLE; no busy, no done.
- IDLE, start=1, reserved op: ignored; no state change.
- MUL: one shift-add step per cycle over a 2W-bit product, LSB of multiplier first. Counter decrements; at 0 go to FIX.
- DIV: one restoring shift-subtract step per cycle, producing quotient and W-bit remainder. Counter decrements; at 0 go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Write HI/LO: mult HI = product[2W-1:W], LO = product[W-1:0]; div LO = quotient, HI = remainder.
  - Assert done next cycle, return to IDLE.
- Divide by zero (b == 0, DIV or DIVU):
  - LO = all ones, HI = a unchanged; div_by_zero = 1 with done.
  - Same latency as a normal divide.
- Signed overflow (a = 1<<(W-1), b = all ones, DIV): LO = 1<<(W-1), HI = 0, no flag.
- start while busy: ignored, never queued.
- abort while busy: return to IDLE next edge; HI/LO unchanged, no done. abort in IDLE is a no-op.
- abort and start in the same IDLE cycle: start wins.
- Reset (any state, including mid-operation): IDLE; hi = lo = 0; busy = done = div_by_zero = 0. The counter and all datapath registers are cleared.

## Timing
- Edge 0: start sampled in IDLE; busy = 1 after edge 0.
- Edges 1..W: W iterations.
- Edge W+1: FIX writes HI/LO. Then busy = 0 and done = 1 for exactly one cycle. Latency is W+1 cycles, i.e. 33 at W=32.
- A new start may be accepted in the cycle done is high; its busy rises on the following edge.
- MTHI/MTLO: HI/LO updated 1 edge after start.
- busy, done and div_by_zero are registered outputs; no combinational path from inputs.

## Structure
- Package mdu_pkg holds:
  - op encodings (OP_MULT … OP_MTLO);
  - the state enum (S_IDLE, S_MUL, S_DIV, S_FIX);
  - a function abs_w and a negate helper.
- One sub-module, mdu_addsub: W+1-bit adder/subtractor shared by the MUL and DIV steps. It exists so one adder is instantiated rather than two.
- HI/LO, FSM and counter stay in iterative_mdu.

## Test plan
- MULT a=FFFFFFFD (−3), b=5 → after 33 cycles hi=FFFFFFFF, lo=FFFFFFF1, done one cycle.
- MULTU a=b=FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0, div_by_zero=0.
- DIVU a=00001234, b=0 → lo=FFFFFFFF, hi=00001234, div_by_zero=1 with done.
- Control and boundary:
  - Second start at cycle 5 of a MULT is ignored; result equals the first op only.
  - abort at cycle 10 keeps the prior HI/LO with no done.
  - rst low at cycle 10 gives hi=lo=0, busy=0 immediately.
  - MTHI a=CAFEF00D gives hi=CAFEF00D next edge with done=0.
